// File: rtl/ascon_aead_stream_if.sv
// Stream bundle between the host fabric and the Ascon AEAD engine.
// A transfer on any channel happens on a rising clk edge where its valid and ready are both 1.
// valid, and the payload qualified by it, stays stable until that edge. ready may depend on
// state, and din_ready may also depend on din_type.
interface ascon_aead_stream_if #(
    parameter int RATE = 64
);
    localparam int NBW = $clog2(RATE / 8 + 1);

    logic             start_valid;
    logic             start_ready;
    logic [127:0]     key;
    logic [127:0]     nonce;
    logic             dec;
    logic [127:0]     tag_in;

    logic [RATE-1:0]  din;
    logic             din_type;
    logic             din_last;
    logic [NBW-1:0]   din_nbytes;
    logic             din_valid;
    logic             din_ready;

    logic [RATE-1:0]  dout;
    logic [NBW-1:0]   dout_nbytes;
    logic             dout_valid;
    logic             dout_ready;

    logic [127:0]     tag_out;
    logic             auth_ok;
    logic             tag_valid;
    logic             tag_ready;

    logic [3:0]       dbg_state;

    modport master (
        output start_valid, key, nonce, dec, tag_in,
        output din, din_type, din_last, din_nbytes, din_valid,
        output dout_ready, tag_ready,
        input  start_ready, din_ready, dout, dout_nbytes, dout_valid,
        input  tag_out, auth_ok, tag_valid, dbg_state
    );

    modport slave (
        input  start_valid, key, nonce, dec, tag_in,
        input  din, din_type, din_last, din_nbytes, din_valid,
        input  dout_ready, tag_ready,
        output start_ready, din_ready, dout, dout_nbytes, dout_valid,
        output tag_out, auth_ok, tag_valid, dbg_state
    );
endinterface

// File: rtl/ascon_aead_stream.sv
// Ascon v1.2 AEAD engine (Ascon-128 when RATE=64, Ascon-128a when RATE=128), NUMR rounds/cycle.
// State S is x0..x4 from MSB down; the rate part is the top RATE bits.
module ascon_aead_stream #(
    parameter int RATE = 64,
    parameter int NUMR = 2
) (
    input logic                clk,
    input logic                rst,
    ascon_aead_stream_if.slave bus
);
    localparam int NB  = RATE / 8;
    localparam int NBW = $clog2(NB + 1);
    localparam int B   = (RATE == 64) ? 6 : 8;
    localparam logic [63:0] IV = (RATE == 64) ? 64'h80400c0600000000 : 64'h80800c0800000000;
    localparam logic [3:0] R_STEP = 4'(NUMR);
    localparam logic [3:0] R_PB   = 4'(12 - B);

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_INIT     = 4'd1,
        S_AD_WAIT  = 4'd2,
        S_AD_PERM  = 4'd3,
        S_MSG_WAIT = 4'd4,
        S_MSG_OUT  = 4'd5,
        S_MSG_PERM = 4'd6,
        S_FINAL    = 4'd7,
        S_TAG      = 4'd8
    } state_t;

    state_t          state_q, state_d;
    logic [319:0]    s_q, s_d;
    logic [127:0]    key_q, key_d;
    logic [127:0]    tag_exp_q, tag_exp_d;
    logic [127:0]    tag_q, tag_d;
    logic            dec_q, dec_d;
    logic            last_q, last_d;
    logic [3:0]      round_q, round_d;
    logic [RATE-1:0] dout_q, dout_d;
    logic [NBW-1:0]  dout_nb_q, dout_nb_d;
    logic            dout_valid_q, dout_valid_d;
    logic            tag_valid_q, tag_valid_d;
    logic            auth_ok_q, auth_ok_d;

    logic [319:0]    perm_s;
    logic            perm_last;
    logic [RATE-1:0] s_rate, dmask, padb, out_blk, ad_rate, msg_rate;
    logic [127:0]    tag_calc;
    logic [319:0]    key_fin;
    logic            ad_beat, msg_beat;

    function automatic logic [63:0] ror(input logic [63:0] x, input int n);
        return (x >> n) | (x << (64 - n));
    endfunction

    function automatic logic [319:0] ascon_round(input logic [319:0] s, input logic [3:0] r);
        logic [63:0] x0, x1, x2, x3, x4, t0, t1, t2, t3, t4;
        x0 = s[319:256];
        x1 = s[255:192];
        x2 = s[191:128] ^ {56'd0, 4'hf - r, r};
        x3 = s[127:64];
        x4 = s[63:0];
        x0 = x0 ^ x4;
        x4 = x4 ^ x3;
        x2 = x2 ^ x1;
        t0 = x0 ^ (~x1 & x2);
        t1 = x1 ^ (~x2 & x3);
        t2 = x2 ^ (~x3 & x4);
        t3 = x3 ^ (~x4 & x0);
        t4 = x4 ^ (~x0 & x1);
        t1 = t1 ^ t0;
        t0 = t0 ^ t4;
        t3 = t3 ^ t2;
        t2 = ~t2;
        x0 = t0 ^ ror(t0, 19) ^ ror(t0, 28);
        x1 = t1 ^ ror(t1, 61) ^ ror(t1, 39);
        x2 = t2 ^ ror(t2, 1) ^ ror(t2, 6);
        x3 = t3 ^ ror(t3, 10) ^ ror(t3, 17);
        x4 = t4 ^ ror(t4, 7) ^ ror(t4, 41);
        return {x0, x1, x2, x3, x4};
    endfunction

    always_comb begin
        perm_s = s_q;
        for (int i = 0; i < NUMR; i++) begin
            perm_s = ascon_round(perm_s, round_q + 4'(i));
        end
        perm_last = (round_q + R_STEP) == 4'd12;
        tag_calc  = perm_s[127:0] ^ key_q;
        key_fin   = 320'({key_q, {(192 - RATE){1'b0}}});
    end

    // Byte j sits at bits [RATE-1-8j -: 8]; the 0x80 pad byte only lands on a last block.
    always_comb begin
        s_rate = s_q[319 -: RATE];
        dmask  = '0;
        padb   = '0;
        for (int j = 0; j < NB; j++) begin
            if (j < int'(bus.din_nbytes)) begin
                dmask[RATE-1-8*j -: 8] = 8'hff;
            end else if (bus.din_last && j == int'(bus.din_nbytes)) begin
                padb[RATE-1-8*j -: 8] = 8'h80;
            end
        end
        out_blk  = (s_rate ^ bus.din) & dmask;
        ad_rate  = s_rate ^ (bus.din & dmask) ^ padb;
        // Absorbing the plaintext makes the rate equal C on valid bytes for both directions.
        msg_rate = s_rate ^ (dec_q ? out_blk : (bus.din & dmask)) ^ padb;
    end

    assign ad_beat  = bus.din_valid && (state_q == S_AD_WAIT) && !bus.din_type;
    assign msg_beat = bus.din_valid && (state_q == S_MSG_WAIT) && bus.din_type;

    always_comb begin
        state_d      = state_q;
        s_d          = s_q;
        key_d        = key_q;
        tag_exp_d    = tag_exp_q;
        tag_d        = tag_q;
        dec_d        = dec_q;
        last_d       = last_q;
        round_d      = round_q;
        dout_d       = dout_q;
        dout_nb_d    = dout_nb_q;
        dout_valid_d = dout_valid_q;
        tag_valid_d  = tag_valid_q;
        auth_ok_d    = auth_ok_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start_valid) begin
                    s_d       = {IV, bus.key, bus.nonce};
                    key_d     = bus.key;
                    dec_d     = bus.dec;
                    tag_exp_d = bus.tag_in;
                    round_d   = 4'd0;
                    state_d   = S_INIT;
                end
            end
            S_INIT: begin
                s_d     = perm_s;
                round_d = round_q + R_STEP;
                if (perm_last) begin
                    s_d     = perm_s ^ {192'd0, key_q};
                    state_d = S_AD_WAIT;
                end
            end
            S_AD_WAIT: begin
                if (ad_beat) begin
                    s_d[319 -: RATE] = ad_rate;
                    last_d  = bus.din_last;
                    round_d = R_PB;
                    state_d = S_AD_PERM;
                end else if (bus.din_valid && bus.din_type) begin
                    // Empty AD: the message beat waits; only the domain separation bit is applied.
                    s_d     = s_q ^ 320'd1;
                    state_d = S_MSG_WAIT;
                end
            end
            S_AD_PERM: begin
                s_d     = perm_s;
                round_d = round_q + R_STEP;
                if (perm_last) begin
                    if (last_q) begin
                        s_d     = perm_s ^ 320'd1;
                        state_d = S_MSG_WAIT;
                    end else begin
                        state_d = S_AD_WAIT;
                    end
                end
            end
            S_MSG_WAIT: begin
                if (msg_beat) begin
                    s_d[319 -: RATE] = msg_rate;
                    dout_d       = out_blk;
                    dout_nb_d    = bus.din_nbytes;
                    dout_valid_d = 1'b1;
                    last_d       = bus.din_last;
                    state_d      = S_MSG_OUT;
                end
            end
            S_MSG_OUT: begin
                if (bus.dout_ready) begin
                    dout_valid_d = 1'b0;
                    if (last_q) begin
                        s_d     = s_q ^ key_fin;
                        round_d = 4'd0;
                        state_d = S_FINAL;
                    end else begin
                        round_d = R_PB;
                        state_d = S_MSG_PERM;
                    end
                end
            end
            S_MSG_PERM: begin
                s_d     = perm_s;
                round_d = round_q + R_STEP;
                if (perm_last) state_d = S_MSG_WAIT;
            end
            S_FINAL: begin
                s_d     = perm_s;
                round_d = round_q + R_STEP;
                if (perm_last) begin
                    tag_d       = tag_calc;
                    auth_ok_d   = dec_q ? (tag_calc == tag_exp_q) : 1'b1;
                    tag_valid_d = 1'b1;
                    state_d     = S_TAG;
                end
            end
            S_TAG: begin
                if (bus.tag_ready) begin
                    tag_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            s_q          <= '0;
            key_q        <= '0;
            tag_exp_q    <= '0;
            tag_q        <= '0;
            dec_q        <= 1'b0;
            last_q       <= 1'b0;
            round_q      <= '0;
            dout_q       <= '0;
            dout_nb_q    <= '0;
            dout_valid_q <= 1'b0;
            tag_valid_q  <= 1'b0;
            auth_ok_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            s_q          <= s_d;
            key_q        <= key_d;
            tag_exp_q    <= tag_exp_d;
            tag_q        <= tag_d;
            dec_q        <= dec_d;
            last_q       <= last_d;
            round_q      <= round_d;
            dout_q       <= dout_d;
            dout_nb_q    <= dout_nb_d;
            dout_valid_q <= dout_valid_d;
            tag_valid_q  <= tag_valid_d;
            auth_ok_q    <= auth_ok_d;
        end
    end

    assign bus.start_ready = (state_q == S_IDLE);
    assign bus.din_ready   = ((state_q == S_AD_WAIT) && !bus.din_type)
                          || ((state_q == S_MSG_WAIT) && bus.din_type);
    assign bus.dout        = dout_q;
    assign bus.dout_nbytes = dout_nb_q;
    assign bus.dout_valid  = dout_valid_q;
    assign bus.tag_out     = tag_q;
    assign bus.auth_ok     = auth_ok_q;
    assign bus.tag_valid   = tag_valid_q;
    assign bus.dbg_state   = state_q;
endmodule
